// File: rtl/ddr_latency_meter_if.sv
// Control and statistics bundle between the test controller and ddr_latency_meter.
// The controller drives the pulses and request/response strobes; the meter drives the statistics.
interface ddr_latency_meter_if #(
    parameter int DEPTH = 16,
    parameter int TW    = 16,
    parameter int CW    = 32,
    parameter int SW    = 48
);
    localparam int OW = $clog2(DEPTH) + 1;

    logic          start;
    logic          stop;
    logic          req_valid;
    logic          resp_valid;
    logic          busy;
    logic [OW-1:0] outstanding;
    logic [TW-1:0] last_lat;
    logic          last_valid;
    logic [TW-1:0] lat_min;
    logic [TW-1:0] lat_max;
    logic [SW-1:0] lat_sum;
    logic [CW-1:0] lat_cnt;
    logic          ovf;
    logic          unf;

    modport master (
        output start, stop, req_valid, resp_valid,
        input  busy, outstanding, last_lat, last_valid,
        input  lat_min, lat_max, lat_sum, lat_cnt, ovf, unf
    );

    modport slave (
        input  start, stop, req_valid, resp_valid,
        output busy, outstanding, last_lat, last_valid,
        output lat_min, lat_max, lat_sum, lat_cnt, ovf, unf
    );
endinterface

// File: rtl/ddr_latency_meter.sv
// Round-trip latency meter: timestamps each request into an in-order FIFO and
// matches it against the next response, accumulating min/max/sum/count statistics.
module ddr_latency_meter #(
    parameter int DEPTH = 16,
    parameter int TW    = 16,
    parameter int CW    = 32,
    parameter int SW    = 48
) (
    input logic               clk,
    input logic               rstn,
    ddr_latency_meter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;

    logic [TW-1:0] ts_r;
    logic [TW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [OW-1:0] count_r;

    logic          busy_r;
    logic          last_valid_r;
    logic          ovf_r;
    logic          unf_r;
    logic [TW-1:0] last_lat_r;
    logic [TW-1:0] lat_min_r;
    logic [TW-1:0] lat_max_r;
    logic [SW-1:0] lat_sum_r;
    logic [CW-1:0] lat_cnt_r;

    logic          accept_req_s;
    logic          accept_resp_s;
    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic          ovf_set_s;
    logic          unf_set_s;
    logic [TW-1:0] lat_s;
    logic [SW:0]   sum_ext_s;
    logic [SW-1:0] sum_sat_s;

    assign empty_s = (count_r == {OW{1'b0}});
    assign full_s  = (count_r == OW'(DEPTH));

    // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds.
    assign pop_s     = accept_resp_s & bus.resp_valid & ~empty_s;
    assign push_s    = accept_req_s & bus.req_valid & (~full_s | pop_s);
    assign ovf_set_s = accept_req_s & bus.req_valid & full_s & ~pop_s;
    assign unf_set_s = accept_resp_s & bus.resp_valid & empty_s;

    // Modular subtraction makes wrapped timestamps come out right.
    assign lat_s = ts_r - mem_r[rd_ptr_r];

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; start overrides everything including stop
    always_comb begin
        state_nx_s = state_r;
        if (bus.start) begin
            state_nx_s = ST_RUN;
        end else begin
            case (state_r)
                ST_IDLE:  state_nx_s = ST_IDLE;
                ST_RUN:   state_nx_s = bus.stop ? ST_DRAIN : ST_RUN;
                ST_DRAIN: state_nx_s = empty_s ? ST_IDLE : ST_DRAIN;
                default:  state_nx_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: which strobes are honoured this cycle
    always_comb begin
        accept_req_s  = 1'b0;
        accept_resp_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                accept_req_s  = ~bus.start;
                accept_resp_s = ~bus.start;
            end
            ST_DRAIN: begin
                accept_req_s  = 1'b0;
                accept_resp_s = ~bus.start;
            end
            default: begin
                accept_req_s  = 1'b0;
                accept_resp_s = 1'b0;
            end
        endcase
    end

    // Saturating latency-sum adder
    always_comb begin
        sum_ext_s = {1'b0, lat_sum_r} + (SW + 1)'(lat_s);
        if (sum_ext_s[SW]) begin
            sum_sat_s = {SW{1'b1}};
        end else begin
            sum_sat_s = sum_ext_s[SW-1:0];
        end
    end

    // Free-running timestamp counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ts_r <= {TW{1'b0}};
        end else begin
            ts_r <= ts_r + TW'(1);
        end
    end

    // Timestamp storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= ts_r;
        end
    end

    // FIFO pointers and occupancy; start flushes
    always_ff @(posedge clk) begin
        if (!rstn || bus.start) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {OW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + OW'(1);
                2'b01:   count_r <= count_r - OW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Busy flag tracks the state being entered
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != ST_IDLE);
        end
    end

    // Latency statistics
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_lat_r   <= {TW{1'b0}};
            last_valid_r <= 1'b0;
            lat_min_r    <= {TW{1'b1}};
            lat_max_r    <= {TW{1'b0}};
            lat_sum_r    <= {SW{1'b0}};
            lat_cnt_r    <= {CW{1'b0}};
        end else if (bus.start) begin
            last_valid_r <= 1'b0;
            lat_min_r    <= {TW{1'b1}};
            lat_max_r    <= {TW{1'b0}};
            lat_sum_r    <= {SW{1'b0}};
            lat_cnt_r    <= {CW{1'b0}};
        end else if (pop_s) begin
            last_lat_r   <= lat_s;
            last_valid_r <= 1'b1;
            lat_sum_r    <= sum_sat_s;
            if (lat_cnt_r != {CW{1'b1}}) begin
                lat_cnt_r <= lat_cnt_r + CW'(1);
            end
            if (lat_s < lat_min_r) begin
                lat_min_r <= lat_s;
            end
            if (lat_s > lat_max_r) begin
                lat_max_r <= lat_s;
            end
        end else begin
            last_valid_r <= 1'b0;
        end
    end

    // Sticky overflow/underflow flags
    always_ff @(posedge clk) begin
        if (!rstn || bus.start) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | ovf_set_s;
            unf_r <= unf_r | unf_set_s;
        end
    end

    assign bus.busy        = busy_r;
    assign bus.outstanding = count_r;
    assign bus.last_lat    = last_lat_r;
    assign bus.last_valid  = last_valid_r;
    assign bus.lat_min     = lat_min_r;
    assign bus.lat_max     = lat_max_r;
    assign bus.lat_sum     = lat_sum_r;
    assign bus.lat_cnt     = lat_cnt_r;
    assign bus.ovf         = ovf_r;
    assign bus.unf         = unf_r;
endmodule

// File: tb/tb_ddr_latency_meter.sv
// Directed bench for ddr_latency_meter: a table of per-cycle vectors with
// hand-computed results, plus short sequences for FIFO-full, drain and reset.
module tb_ddr_latency_meter;
    localparam int DEPTH = 16;
    localparam int TW    = 16;
    localparam int CW    = 32;
    localparam int SW    = 48;
    localparam int MINR  = 65535;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_err;

    ddr_latency_meter_if #(.DEPTH(DEPTH), .TW(TW), .CW(CW), .SW(SW)) bus ();

    ddr_latency_meter #(.DEPTH(DEPTH), .TW(TW), .CW(CW), .SW(SW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int st, sp, rq, rs;
        int busy, outs, lv, lat, lmin, lmax, lsum, lcnt, ovf, unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int st, int sp, int rq, int rs, int busy, int outs, int lv,
                                int lat, int lmin, int lmax, int lsum, int lcnt, int ovf, int unf);
        vec_t v;
        v.st = st; v.sp = sp; v.rq = rq; v.rs = rs;
        v.busy = busy; v.outs = outs; v.lv = lv; v.lat = lat;
        v.lmin = lmin; v.lmax = lmax; v.lsum = lsum; v.lcnt = lcnt;
        v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock cycle with the given strobes; outputs sampled 1 time unit after the edge.
    task automatic cyc(input bit st, input bit sp, input bit rq, input bit rs);
        bus.start      = st;
        bus.stop       = sp;
        bus.req_valid  = rq;
        bus.resp_valid = rs;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".busy"},  64'(bus.busy), 0);
        chk({tag, ".outs"},  64'(bus.outstanding), 0);
        chk({tag, ".lat"},   64'(bus.last_lat), 0);
        chk({tag, ".lv"},    64'(bus.last_valid), 0);
        chk({tag, ".min"},   64'(bus.lat_min), MINR);
        chk({tag, ".max"},   64'(bus.lat_max), 0);
        chk({tag, ".sum"},   64'(bus.lat_sum), 0);
        chk({tag, ".cnt"},   64'(bus.lat_cnt), 0);
        chk({tag, ".ovf"},   64'(bus.ovf), 0);
        chk({tag, ".unf"},   64'(bus.unf), 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.req_valid = 1'b0; bus.resp_valid = 1'b0;

        //             st sp rq rs  busy outs lv lat  min   max sum cnt ovf unf
        vecs.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, MINR, 0, 0,  0, 0, 0)); // v0 start
        vecs.push_back(mk(0, 0, 1, 0,  1, 1, 0, 0, MINR, 0, 0,  0, 0, 0)); // v1 req
        for (int i = 2; i < 8; i++)
            vecs.push_back(mk(0, 0, 0, 0,  1, 1, 0, 0, MINR, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 0, 1, 7, 7,    7, 7,  1, 0, 0)); // v8 resp, lat 7
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 7,    7, 7,  1, 0, 0)); // v9
        vecs.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, MINR, 0, 0,  0, 0, 0)); // v10 restart
        vecs.push_back(mk(0, 0, 1, 0,  1, 1, 0, 0, MINR, 0, 0,  0, 0, 0)); // v11 req A
        vecs.push_back(mk(0, 0, 0, 0,  1, 1, 0, 0, MINR, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 1, 0, 0, MINR, 0, 0,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0,  1, 2, 0, 0, MINR, 0, 0,  0, 0, 0)); // v14 req B
        vecs.push_back(mk(0, 0, 1, 0,  1, 3, 0, 0, MINR, 0, 0,  0, 0, 0)); // v15 req C
        vecs.push_back(mk(0, 0, 0, 1,  1, 2, 1, 5, 5,    5, 5,  1, 0, 0)); // v16 A lat 5
        vecs.push_back(mk(0, 0, 0, 1,  1, 1, 1, 3, 3,    5, 8,  2, 0, 0)); // v17 B lat 3
        for (int i = 18; i < 24; i++)
            vecs.push_back(mk(0, 0, 0, 0,  1, 1, 0, 0, 3, 5, 8, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1, 0, 1, 9, 3,    9, 17, 3, 0, 0)); // v24 C lat 9
        vecs.push_back(mk(0, 0, 0, 1,  1, 0, 0, 0, 3,    9, 17, 3, 0, 1)); // v25 unf
        vecs.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, MINR, 0, 0,  0, 0, 0)); // v26 start clears unf
        vecs.push_back(mk(0, 0, 1, 1,  1, 1, 0, 0, MINR, 0, 0,  0, 0, 1)); // v27 req+resp empty
        vecs.push_back(mk(0, 0, 0, 1,  1, 0, 1, 1, 1,    1, 1,  1, 0, 1)); // v28 lat 1
        vecs.push_back(mk(1, 1, 0, 0,  1, 0, 0, 0, MINR, 0, 0,  0, 0, 0)); // v29 start+stop
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, MINR, 0, 0,  0, 0, 0)); // v30 still RUN
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, MINR, 0, 0,  0, 0, 0)); // v31

        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        rstn = 1'b1;
        cyc(0, 0, 1, 1);
        chk("idle.outs", 64'(bus.outstanding), 0);
        chk("idle.unf",  64'(bus.unf), 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].st[0], vecs[i].sp[0], vecs[i].rq[0], vecs[i].rs[0]);
            chk($sformatf("v%0d.busy", i), 64'(bus.busy), 64'(vecs[i].busy));
            chk($sformatf("v%0d.outs", i), 64'(bus.outstanding), 64'(vecs[i].outs));
            chk($sformatf("v%0d.lv", i),   64'(bus.last_valid), 64'(vecs[i].lv));
            if (vecs[i].lv != 0)
                chk($sformatf("v%0d.lat", i), 64'(bus.last_lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d.min", i),  64'(bus.lat_min), 64'(vecs[i].lmin));
            chk($sformatf("v%0d.max", i),  64'(bus.lat_max), 64'(vecs[i].lmax));
            chk($sformatf("v%0d.sum", i),  64'(bus.lat_sum), 64'(vecs[i].lsum));
            chk($sformatf("v%0d.cnt", i),  64'(bus.lat_cnt), 64'(vecs[i].lcnt));
            chk($sformatf("v%0d.ovf", i),  64'(bus.ovf), 64'(vecs[i].ovf));
            chk($sformatf("v%0d.unf", i),  64'(bus.unf), 64'(vecs[i].unf));
        end

        // Overflow: 17th request alone is dropped
        cyc(1, 0, 0, 0);
        repeat (DEPTH) cyc(0, 0, 1, 0);
        chk("full.outs", 64'(bus.outstanding), 16);
        chk("full.ovf0", 64'(bus.ovf), 0);
        cyc(0, 0, 1, 0);
        chk("ovf.outs", 64'(bus.outstanding), 16);
        chk("ovf.set",  64'(bus.ovf), 1);

        // Full FIFO with simultaneous response: push succeeds
        cyc(1, 0, 0, 0);
        chk("restart.outs", 64'(bus.outstanding), 0);
        chk("restart.ovf",  64'(bus.ovf), 0);
        repeat (DEPTH) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        chk("fullrr.outs", 64'(bus.outstanding), 16);
        chk("fullrr.ovf",  64'(bus.ovf), 0);
        chk("fullrr.lv",   64'(bus.last_valid), 1);
        chk("fullrr.lat",  64'(bus.last_lat), 16);

        // Drain: requests ignored after stop, busy until the last response
        cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        chk("drain.busy0", 64'(bus.busy), 1);
        repeat (2) cyc(0, 0, 1, 0);
        chk("drain.outs4", 64'(bus.outstanding), 4);
        chk("drain.ovf",   64'(bus.ovf), 0);
        repeat (3) cyc(0, 0, 0, 1);
        chk("drain.outs1", 64'(bus.outstanding), 1);
        chk("drain.busy1", 64'(bus.busy), 1);
        cyc(0, 0, 0, 1);
        chk("drain.outs0", 64'(bus.outstanding), 0);
        chk("drain.cnt",   64'(bus.lat_cnt), 4);
        chk("drain.lat",   64'(bus.last_lat), 7);
        repeat (2) cyc(0, 0, 0, 0);
        chk("drain.idle",  64'(bus.busy), 0);

        // Stop with empty FIFO: one DRAIN cycle, then IDLE
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("estop.busy1", 64'(bus.busy), 1);
        cyc(0, 0, 0, 0);
        chk("estop.busy0", 64'(bus.busy), 0);

        // Reset mid-run with 5 outstanding
        cyc(1, 0, 0, 0);
        repeat (6) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        chk("mid.outs", 64'(bus.outstanding), 5);
        chk("mid.cnt",  64'(bus.lat_cnt), 1);
        rstn = 1'b0;
        cyc(0, 0, 0, 0);
        chk_reset("midrst");
        rstn = 1'b1;
        cyc(0, 0, 0, 1);
        chk("post.unf",  64'(bus.unf), 0);
        chk("post.busy", 64'(bus.busy), 0);
        chk("post.cnt",  64'(bus.lat_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
